// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the frame-parser state encoding and the abort reason codes.
package imem_boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_SYNC  = 3'd1;
    localparam logic [2:0] ERR_ALIGN = 3'd2;
    localparam logic [2:0] ERR_ZERO  = 3'd3;
    localparam logic [2:0] ERR_OVF   = 3'd4;
    localparam logic [2:0] ERR_CSUM  = 3'd5;

endpackage

// File: rtl/imem_word_packer.sv
// Shifts payload bytes into a big-endian word; word_valid flags the 4th byte
// so the caller can register the completed word in the same cycle.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear) begin
            idx_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid) begin
            idx_d   = idx_q + 2'd1;
            shift_d = {shift_q[15:0], byte_data};
        end
    end

    always_comb begin
        word_valid = byte_valid && (idx_q == 2'd3);
        word       = {shift_q, byte_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Parses a framed boot byte stream and writes the payload as big-endian words
// into instruction memory, holding the CPU until the frame finishes or aborts.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int         ADDR_W    = 14,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code,
    output logic [ADDR_W-2:0] words_loaded
);

    boot_state_e state_q, state_d;

    logic [15:0]       addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-2:0] words_q, words_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [2:0]        err_code_q, err_code_d;

    logic        accept;
    logic        start_ok;
    logic        last_word;
    logic [15:0] new_cnt;
    logic [31:0] end_addr;
    logic [2:0]  fail_code;
    logic        word_valid;
    logic [31:0] packed_word;

    assign accept    = in_valid && in_ready;
    assign start_ok  = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign new_cnt   = {cnt_q[7:0], in_data};
    // Computed in 32 bits so a large count can never wrap past the memory end
    assign end_addr  = 32'(addr_q) + (32'(new_cnt) << 2);
    assign last_word = (16'(words_q) + 16'd1) == cnt_q;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_valid (accept && (state_q == ST_DATA)),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fail_code = ERR_NONE;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_SYNC;
            ST_SYNC: if (accept) begin
                if (in_data != SYNC_BYTE) fail_code = ERR_SYNC;
                else                      state_d   = ST_ADDR_HI;
            end
            ST_ADDR_HI: if (accept) state_d = ST_ADDR_LO;
            ST_ADDR_LO: if (accept) begin
                if (in_data[1:0] != 2'b00) fail_code = ERR_ALIGN;
                else                       state_d   = ST_CNT_HI;
            end
            ST_CNT_HI: if (accept) state_d = ST_CNT_LO;
            ST_CNT_LO: if (accept) begin
                if (new_cnt == 16'd0)                      fail_code = ERR_ZERO;
                else if (end_addr > (32'd1 << ADDR_W))     fail_code = ERR_OVF;
                else                                       state_d   = ST_DATA;
            end
            ST_DATA: if (word_valid && last_word) state_d = ST_CSUM;
            ST_CSUM: if (accept) begin
                if (in_data != csum_q) fail_code = ERR_CSUM;
                else                   state_d   = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (fail_code != ERR_NONE) state_d = ST_ERR;
    end

    always_comb begin
        in_ready = state_q inside {ST_SYNC, ST_ADDR_HI, ST_ADDR_LO, ST_CNT_HI,
                                   ST_CNT_LO, ST_DATA, ST_CSUM};
    end

    always_comb begin
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        words_d     = words_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;

        if (start_ok) begin
            done_d     = 1'b0;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            words_d    = '0;
            busy_d     = 1'b1;
            csum_d     = 8'd0;
        end

        if (accept) begin
            case (state_q)
                ST_ADDR_HI, ST_ADDR_LO: addr_d = {addr_q[7:0], in_data};
                ST_CNT_HI,  ST_CNT_LO:  cnt_d  = {cnt_q[7:0], in_data};
                ST_DATA:                csum_d = csum_q ^ in_data;
                default: ;
            endcase
        end

        // addr_q doubles as the running write pointer once the payload starts
        if (word_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = 32'(addr_q);
            mem_wdata_d = packed_word;
            addr_d      = addr_q + 16'd4;
            words_d     = words_q + (ADDR_W-1)'(1);
        end

        if (state_q == ST_CSUM && state_d == ST_DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
        if (state_q != ST_ERR && state_d == ST_ERR) begin
            error_d    = 1'b1;
            err_code_d = fail_code;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= 16'd0;
            cnt_q       <= 16'd0;
            csum_q      <= 8'd0;
            words_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            words_q     <= words_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign cpu_hold     = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good frames, gapped input, each abort
// reason, checksum failure with no rollback, and reset in the middle of a frame.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic [12:0] words_loaded;

    int checks = 0;
    int failures = 0;

    logic [7:0]  fb [0:31];
    int          fl;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    imem_boot_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data_snapshot());
        end
    end

    function automatic logic [31:0] mem_data_snapshot();
        return mem_wdata;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the byte is accepted
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("[TB] FAIL in_ready_timeout byte=%h in_ready=%b required=1", b, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < fl; i++) send_byte(fb[i]);
    endtask

    task automatic load_frame1(input logic [7:0] csum);
        fb[0] = 8'hA5; fb[1] = 8'h00; fb[2] = 8'h64; fb[3] = 8'h00; fb[4] = 8'h02;
        fb[5] = 8'h24; fb[6] = 8'h00; fb[7] = 8'h00; fb[8] = 8'h05;
        fb[9] = 8'h24; fb[10] = 8'h01; fb[11] = 8'h00; fb[12] = 8'h0A;
        fb[13] = csum;
        fl = 14;
    endtask

    task automatic check_frame1_writes(input string tag);
        checks++;
        if (wr_addr.size() !== 2) begin
            failures++;
            $display("[TB] FAIL %s_write_count got=%0d exp=2", tag, wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 32'd100 || wr_data[0] !== 32'h24000005 ||
                wr_addr[1] !== 32'd104 || wr_data[1] !== 32'h2401000A) begin
                failures++;
                $display("[TB] FAIL %s_writes got=%h@%h,%h@%h exp=24000005@00000064,2401000a@00000068",
                         tag, wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if ({in_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0 || err_code !== 3'd0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0 || words_loaded !== 13'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got flags=%b code=%0d addr=%h data=%h words=%0d exp all 0",
                     {in_ready, mem_we, cpu_hold, busy, done, error}, err_code, mem_addr, mem_wdata, words_loaded);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic_frame();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_armed got busy=%b hold=%b ready=%b exp 1 1 1", busy, cpu_hold, in_ready);
        end
        load_frame1(8'h0E);
        send_frame();
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b0 ||
            in_ready !== 1'b0 || words_loaded !== 13'd2) begin
            failures++;
            $display("[TB] FAIL basic_done got done=%b err=%b busy=%b hold=%b ready=%b words=%0d exp 1 0 0 0 0 2",
                     done, error, busy, cpu_hold, in_ready, words_loaded);
        end
        idle(2);
        check_frame1_writes("basic");
    endtask

    task automatic test_gaps();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        load_frame1(8'h0E);
        for (int i = 0; i < fl; i++) begin
            idle(i % 4);
            send_byte(fb[i]);
            if (i == 8 || i == 12) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== ((i == 8) ? 32'd100 : 32'd104)) begin
                    failures++;
                    $display("[TB] FAIL gaps_latency byte=%0d got we=%b addr=%h exp we=1 addr=%h",
                             i, mem_we, mem_addr, (i == 8) ? 32'd100 : 32'd104);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || words_loaded !== 13'd2) begin
            failures++;
            $display("[TB] FAIL gaps_done got done=%b words=%0d exp 1 2", done, words_loaded);
        end
        idle(2);
        check_frame1_writes("gaps");
    endtask

    task automatic test_bad_header();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        fb[0] = 8'hA5; fb[1] = 8'h00; fb[2] = 8'h66; fl = 3;
        send_frame();
        checks++;
        if (error !== 1'b1 || err_code !== 3'd2 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL unaligned got err=%b code=%0d ready=%b busy=%b done=%b exp 1 2 0 0 0",
                     error, err_code, in_ready, busy, done);
        end
        idle(2);
        checks++;
        if (wr_addr.size() !== 0) begin
            failures++;
            $display("[TB] FAIL unaligned_no_write got=%0d exp=0", wr_addr.size());
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || err_code !== 3'd0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_clear got err=%b code=%0d busy=%b exp 0 0 1", error, err_code, busy);
        end
        send_byte(8'h5A);
        checks++;
        if (error !== 1'b1 || err_code !== 3'd1) begin
            failures++;
            $display("[TB] FAIL bad_sync got err=%b code=%0d exp 1 1", error, err_code);
        end
    endtask

    task automatic test_bounds();
        pulse_start();
        fb[0] = 8'hA5; fb[1] = 8'h3F; fb[2] = 8'hFC; fb[3] = 8'h00; fb[4] = 8'h02; fl = 5;
        send_frame();
        checks++;
        if (error !== 1'b1 || err_code !== 3'd4) begin
            failures++;
            $display("[TB] FAIL overflow got err=%b code=%0d exp 1 4", error, err_code);
        end
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        fb[4] = 8'h01; fb[5] = 8'h11; fb[6] = 8'h22; fb[7] = 8'h33; fb[8] = 8'h44; fb[9] = 8'h44; fl = 10;
        send_frame();
        idle(2);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || wr_addr.size() !== 1 || words_loaded !== 13'd1) begin
            failures++;
            $display("[TB] FAIL top_word got done=%b err=%b writes=%0d words=%0d exp 1 0 1 1",
                     done, error, wr_addr.size(), words_loaded);
        end else begin
            checks++;
            if (wr_addr[0] !== 32'h3FFC || wr_data[0] !== 32'h11223344) begin
                failures++;
                $display("[TB] FAIL top_word_data got %h@%h exp 11223344@00003ffc", wr_data[0], wr_addr[0]);
            end
        end
        pulse_start();
        fb[0] = 8'hA5; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00; fb[4] = 8'h00; fl = 5;
        send_frame();
        checks++;
        if (error !== 1'b1 || err_code !== 3'd3 || words_loaded !== 13'd0) begin
            failures++;
            $display("[TB] FAIL zero_count got err=%b code=%0d words=%0d exp 1 3 0", error, err_code, words_loaded);
        end
    endtask

    task automatic test_bad_csum();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        load_frame1(8'h0F);
        send_frame();
        checks++;
        if (error !== 1'b1 || err_code !== 3'd5 || done !== 1'b0 || words_loaded !== 13'd2 || cpu_hold !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bad_csum got err=%b code=%0d done=%b words=%0d hold=%b exp 1 5 0 2 0",
                     error, err_code, done, words_loaded, cpu_hold);
        end
        idle(2);
        check_frame1_writes("csum");
    endtask

    task automatic test_reset_mid_frame();
        pulse_start();
        load_frame1(8'h0E);
        fl = 7;
        send_frame();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0 || err_code !== 3'd0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0 || words_loaded !== 13'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset got flags=%b code=%0d addr=%h data=%h words=%0d exp all 0",
                     {in_ready, mem_we, cpu_hold, busy, done, error}, err_code, mem_addr, mem_wdata, words_loaded);
        end
        rst = 1'b0;
        idle(1);
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        load_frame1(8'h0E);
        send_frame();
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 13'd2) begin
            failures++;
            $display("[TB] FAIL after_reset got done=%b err=%b words=%0d exp 1 0 2", done, error, words_loaded);
        end
        idle(2);
        check_frame1_writes("after_reset");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_gaps();
        test_bad_header();
        test_bounds();
        test_bad_csum();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
